// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin sharing of single-ported main memory between I-cache and D-cache miss paths
// One access in flight: latch the winner's request, hold memory for LATENCY cycles, then pulse done.
module mem_arbiter #(
    parameter int LATENCY = 20,
    parameter int CNTW    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic        idone,
    output logic [31:0] irdata,
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic        ddone,
    output logic [31:0] drdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic SIDE_I = 1'b0;
    localparam logic SIDE_D = 1'b1;
    localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CNTW-1:0]   r_count;
    logic              r_last_gnt;
    logic              r_owner;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_irdata;
    logic [31:0]       r_drdata;

    logic              w_any_req;
    logic              w_grant_d;
    logic              w_last_beat;

    assign w_any_req   = ireq | dreq;
    // On a tie the side that did not win last time goes next; last_gnt resets to I so D wins the first tie.
    assign w_grant_d   = dreq & (~ireq | (r_last_gnt == SIDE_I));
    assign w_last_beat = (r_count == '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_any_req) w_next = S_BUSY;
            S_BUSY: if (w_last_beat) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_last_gnt <= SIDE_I;
            r_owner    <= SIDE_I;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_irdata   <= '0;
            r_drdata   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_count <= CNT_LOAD;
                        if (w_grant_d) begin
                            r_owner    <= SIDE_D;
                            r_last_gnt <= SIDE_D;
                            r_we       <= dwe;
                            r_addr     <= daddr;
                            r_wdata    <= dwdata;
                        end else begin
                            r_owner    <= SIDE_I;
                            r_last_gnt <= SIDE_I;
                            r_we       <= 1'b0;
                            r_addr     <= iaddr;
                            r_wdata    <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (w_last_beat) begin
                        if (!r_we) begin
                            if (r_owner == SIDE_D) r_drdata <= mem_rdata;
                            else                   r_irdata <= mem_rdata;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign mem_en    = (r_state == S_BUSY);
    assign mem_we    = mem_en & r_we;
    assign mem_addr  = mem_en ? r_addr  : '0;
    assign mem_wdata = mem_we ? r_wdata : '0;
    assign idone     = (r_state == S_DONE) & (r_owner == SIDE_I);
    assign ddone     = (r_state == S_DONE) & (r_owner == SIDE_D);
    assign irdata    = r_irdata;
    assign drdata    = r_drdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (LATENCY=4 main instance, LATENCY=1 side instance)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe;
    logic [31:0] iaddr, daddr, dwdata;
    logic        idone, ddone, mem_en, mem_we, busy;
    logic [31:0] irdata, drdata, mem_addr, mem_wdata, mem_rdata;

    logic        ireq1, dreq1;
    logic [31:0] iaddr1, daddr1;
    logic        idone1, ddone1, mem_en1, mem_we1, busy1;
    logic [31:0] irdata1, drdata1, mem_addr1, mem_wdata1, mem_rdata1;

    logic [31:0] mem [0:1023];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        bit          side;
        logic [31:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.LATENCY(4), .CNTW(5)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .idone(idone), .irdata(irdata),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .ddone(ddone), .drdata(drdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1), .CNTW(5)) dut1 (
        .clk(clk), .reset(reset),
        .ireq(ireq1), .iaddr(iaddr1), .idone(idone1), .irdata(irdata1),
        .dreq(dreq1), .dwe(1'b0), .daddr(daddr1), .dwdata(32'h0),
        .ddone(ddone1), .drdata(drdata1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
    );

    assign mem_rdata  = mem[mem_addr[9:0]];
    assign mem_rdata1 = mem_addr1 ^ 32'h5A5A5A5A;

    always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse of the main instance is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && (idone || ddone)) begin
            check("done_overlap", {31'd0, idone & ddone}, 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("done_side", {31'd0, ddone}, {31'd0, e.side});
                check("done_cycle", cyc, e.due);
                check("rdata", e.side ? drdata : irdata, e.data);
            end
        end
    end

    task automatic push(input bit side, input logic [31:0] data, input int due);
        exp_t e;
        e.side = side; e.data = data; e.due = due;
        sbq.push_back(e);
    endtask

    // Runs until both requests are retired and the arbiter is idle; counts memory cycles.
    task automatic drain(input bit chk, input logic [31:0] caddr, input int change_at,
                         output int n_en, output int n_we);
        int k = 0;
        n_en = 0; n_we = 0;
        while ((ireq || dreq || busy) && k < 60) begin
            @(negedge clk);
            k++;
            if (mem_en) begin
                n_en++;
                if (mem_we) n_we++;
                if (chk) check("mem_addr_stable", mem_addr, caddr);
            end
            if (k == change_at) daddr = 32'h80;
            if (idone) ireq = 1'b0;
            if (ddone) dreq = 1'b0;
        end
        if (k >= 60) check("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; ireq = 0; dreq = 0; ireq1 = 0; dreq1 = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    int n_en, n_we, t0;
    logic [31:0] exp_ird, exp_drd;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[10'h100] = 32'hDEADBEEF;
        mem[10'h104] = 32'h11112222;
        mem[10'h080] = 32'hCAFEF00D;
        reset = 1'b1;
        ireq = 0; dreq = 0; dwe = 0; iaddr = 0; daddr = 0; dwdata = 0;
        ireq1 = 0; dreq1 = 0; iaddr1 = 0; daddr1 = 0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_dones", {30'd0, idone, ddone}, 32'd0);
        check("rst_irdata", irdata, 32'd0);
        check("rst_drdata", drdata, 32'd0);
        check("rst_mem_bus", mem_addr | mem_wdata | {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        exp_ird = 0; exp_drd = 0;

        // I read
        @(negedge clk);
        ireq = 1; iaddr = 32'h100; t0 = cyc;
        push(1'b0, 32'hDEADBEEF, t0 + 5);
        drain(1'b1, 32'h100, 0, n_en, n_we);
        check("iread_en_cycles", n_en, 4);
        exp_ird = 32'hDEADBEEF;

        // D write: drdata must stay at its previous value
        @(negedge clk);
        dreq = 1; dwe = 1; daddr = 32'h40; dwdata = 32'h12345678; t0 = cyc;
        push(1'b1, exp_drd, t0 + 5);
        drain(1'b1, 32'h40, 0, n_en, n_we);
        check("dwrite_we_cycles", n_we, 4);
        check("dwrite_mem", mem[10'h040], 32'h12345678);

        // D read with address changed mid-access
        @(negedge clk);
        dreq = 1; dwe = 0; daddr = 32'h40; t0 = cyc;
        push(1'b1, 32'h12345678, t0 + 5);
        drain(1'b1, 32'h40, 2, n_en, n_we);
        check("dread_en_cycles", n_en, 4);
        check("irdata_held", irdata, exp_ird);

        // Ties after reset: D, I, then D again
        do_reset();
        @(negedge clk);
        ireq = 1; iaddr = 32'h100; dreq = 1; dwe = 0; daddr = 32'h80; t0 = cyc;
        push(1'b1, 32'hCAFEF00D, t0 + 5);
        push(1'b0, 32'hDEADBEEF, t0 + 11);
        drain(1'b0, 32'h0, 0, n_en, n_we);
        check("tie1_en_cycles", n_en, 8);
        @(negedge clk);
        ireq = 1; iaddr = 32'h104; dreq = 1; dwe = 0; daddr = 32'h40; t0 = cyc;
        push(1'b1, 32'h12345678, t0 + 5);
        push(1'b0, 32'h11112222, t0 + 11);
        drain(1'b0, 32'h0, 0, n_en, n_we);
        check("tie2_en_cycles", n_en, 8);

        // Reset during an I read: no done pulse, outputs cleared
        @(negedge clk);
        ireq = 1; iaddr = 32'h100;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_busy", {31'd0, busy}, 32'd1);
        reset = 1; ireq = 0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_mem_en", {31'd0, mem_en}, 32'd0);
        check("abort_irdata", irdata, 32'd0);
        reset = 0;
        repeat (6) @(negedge clk);
        ireq = 1; iaddr = 32'h104; t0 = cyc;
        push(1'b0, 32'h11112222, t0 + 5);
        drain(1'b1, 32'h104, 0, n_en, n_we);
        check("after_abort_en", n_en, 4);

        // LATENCY=1 instance: tie, single BUSY cycle each, never overlapping
        begin
            int td, ti, en1;
            td = -1; ti = -1; en1 = 0;
            @(negedge clk);
            ireq1 = 1; iaddr1 = 32'h200; dreq1 = 1; daddr1 = 32'h300; t0 = cyc;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (mem_en1) en1++;
                check("l1_overlap", {31'd0, idone1 & ddone1}, 32'd0);
                if (ddone1) begin
                    td = cyc; dreq1 = 0;
                    check("l1_drdata", drdata1, 32'h5A5A595A);
                end
                if (idone1) begin
                    ti = cyc; ireq1 = 0;
                    check("l1_irdata", irdata1, 32'h5A5A585A);
                end
            end
            check("l1_ddone_cycle", td, t0 + 2);
            check("l1_idone_cycle", ti, t0 + 5);
            check("l1_en_cycles", en1, 2);
        end

        repeat (2) @(negedge clk);
        check("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
